// File: rtl/bsk_led_ctrl.sv
// bsk_led_ctrl: LED state controller in front of the front-panel LED latch driver.
//
// Holds the transmitter (PRD) and receiver (PRM) LED images, which the local CPU
// writes over a small register bus. It applies per-bit blinking and a timed
// lamp test, and drives the registered 16-bit images that the latch driver consumes.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   iRst         asynchronous active-high reset
//   iWr, iRd     register write / read strobes, sampled on the rising edge
//   iAddr        0 = PRD_ON, 1 = PRM_ON, 2 = PRD_BLINK, 3 = PRM_BLINK
//   iData        write data
//   iLampTest    lamp-test request, level sampled; retriggers while held
//   oRdData      registered read data (read-before-write on simultaneous access)
//   oLedPrd      PRD LED image, 1 = lit
//   oLedPrm      PRM LED image, 1 = lit
//   oBlinkPhase  current blink phase, 1 = on phase
//
// Parameters:
//   BLINK_DIV    clk cycles per blink half-period (2..65535)
//   LAMP_TICKS   clk cycles the lamp test forces every LED on (1..2^20-1)

module bsk_led_ctrl #(
  parameter int unsigned BLINK_DIV  = 50000,
  parameter int unsigned LAMP_TICKS = 100000
) (
  input  logic        clk,
  input  logic        iRst,
  input  logic        iWr,
  input  logic        iRd,
  input  logic [1:0]  iAddr,
  input  logic [15:0] iData,
  input  logic        iLampTest,
  output logic [15:0] oRdData,
  output logic [15:0] oLedPrd,
  output logic [15:0] oLedPrm,
  output logic        oBlinkPhase
);

  // Counter widths are derived from the parameters. The lamp counter must hold
  // LAMP_TICKS-1, and it needs at least one bit even when LAMP_TICKS is 1.
  localparam int unsigned BlinkW = $clog2(BLINK_DIV);
  localparam int unsigned LampW  = $clog2(LAMP_TICKS + 1);

  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);
  localparam logic [BlinkW-1:0] BlinkOne  = BlinkW'(1);
  localparam logic [LampW-1:0]  LampLoad  = LampW'(LAMP_TICKS - 1);
  localparam logic [LampW-1:0]  LampOne   = LampW'(1);

  typedef enum logic [0:0] {
    StIdle,
    StTest
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [15:0]       prd_on_q, prd_on_d;
  logic [15:0]       prm_on_q, prm_on_d;
  logic [15:0]       prd_blink_q, prd_blink_d;
  logic [15:0]       prm_blink_q, prm_blink_d;
  logic [15:0]       rd_data_q, rd_data_d;
  logic [15:0]       led_prd_q, led_prd_d;
  logic [15:0]       led_prm_q, led_prm_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              phase_q, phase_d;
  logic [LampW-1:0]  lamp_cnt_q, lamp_cnt_d;
  state_e            state_q, state_d;

  logic [15:0]       rd_sel;
  logic              blink_wrap;
  logic [15:0]       blink_mask;

  // ---------------------------------------------------------------------------
  // Register bus
  // ---------------------------------------------------------------------------
  // The read mux looks at the current register contents. A write on the same
  // edge therefore returns the old value (read-before-write).
  always_comb begin
    rd_sel = prd_on_q;
    unique case (iAddr)
      2'd0: rd_sel = prd_on_q;
      2'd1: rd_sel = prm_on_q;
      2'd2: rd_sel = prd_blink_q;
      2'd3: rd_sel = prm_blink_q;
      default: rd_sel = prd_on_q;
    endcase
  end

  always_comb begin
    prd_on_d    = prd_on_q;
    prm_on_d    = prm_on_q;
    prd_blink_d = prd_blink_q;
    prm_blink_d = prm_blink_q;
    if (iWr) begin
      unique case (iAddr)
        2'd0: prd_on_d    = iData;
        2'd1: prm_on_d    = iData;
        2'd2: prd_blink_d = iData;
        2'd3: prm_blink_d = iData;
        default: prd_on_d = prd_on_q;
      endcase
    end
  end

  assign rd_data_d = iRd ? rd_sel : rd_data_q;

  // ---------------------------------------------------------------------------
  // Blink timer: free-running and independent of the bus and the lamp test
  // ---------------------------------------------------------------------------
  always_comb begin
    blink_wrap  = (blink_cnt_q == BlinkLast);
    blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + BlinkOne;
    phase_d     = phase_q ^ blink_wrap;
  end

  // ---------------------------------------------------------------------------
  // Lamp-test FSM
  // ---------------------------------------------------------------------------
  // A request always reloads the counter. It takes priority over the
  // expiry check, so holding iLampTest high keeps the FSM in StTest.
  always_comb begin
    state_d    = state_q;
    lamp_cnt_d = lamp_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (iLampTest) begin
          state_d    = StTest;
          lamp_cnt_d = LampLoad;
        end
      end
      StTest: begin
        if (iLampTest) begin
          lamp_cnt_d = LampLoad;
        end else if (lamp_cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          lamp_cnt_d = lamp_cnt_q - LampOne;
        end
      end
      default: begin
        state_d    = StIdle;
        lamp_cnt_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // LED images
  // ---------------------------------------------------------------------------
  // The images are built from the registered state. A write or a phase toggle
  // therefore shows one edge later. Forcing on state_q (not state_d) gives an
  // all-on window that starts the edge after entry and ends on the exit edge.
  always_comb begin
    blink_mask = {16{~phase_q}};
    if (state_q == StTest) begin
      led_prd_d = 16'hFFFF;
      led_prm_d = 16'hFFFF;
    end else begin
      led_prd_d = prd_on_q & ~(prd_blink_q & blink_mask);
      led_prm_d = prm_on_q & ~(prm_blink_q & blink_mask);
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge iRst) begin
    if (iRst) begin
      prd_on_q    <= '0;
      prm_on_q    <= '0;
      prd_blink_q <= '0;
      prm_blink_q <= '0;
      rd_data_q   <= '0;
      led_prd_q   <= '0;
      led_prm_q   <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      lamp_cnt_q  <= '0;
      state_q     <= StIdle;
    end else begin
      prd_on_q    <= prd_on_d;
      prm_on_q    <= prm_on_d;
      prd_blink_q <= prd_blink_d;
      prm_blink_q <= prm_blink_d;
      rd_data_q   <= rd_data_d;
      led_prd_q   <= led_prd_d;
      led_prm_q   <= led_prm_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      lamp_cnt_q  <= lamp_cnt_d;
      state_q     <= state_d;
    end
  end

  assign oRdData     = rd_data_q;
  assign oLedPrd     = led_prd_q;
  assign oLedPrm     = led_prm_q;
  assign oBlinkPhase = phase_q;

endmodule

// File: tb/tb_bsk_led_ctrl.sv
// Self-checking bench for bsk_led_ctrl (BLINK_DIV=4, LAMP_TICKS=5).
// The reference model tracks the edge count since reset and the last edge
// at which the lamp test is still active, and derives every output from those.

module tb_bsk_led_ctrl;

  localparam int unsigned BD = 4;
  localparam int unsigned LT = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [15:0] data = 16'h0;
  logic        lamp = 1'b0;
  logic [15:0] rd_data;
  logic [15:0] led_prd;
  logic [15:0] led_prm;
  logic        phase;

  always #5 clk = ~clk;

  bsk_led_ctrl #(
    .BLINK_DIV (BD),
    .LAMP_TICKS(LT)
  ) dut (
    .clk        (clk),
    .iRst       (rst),
    .iWr        (wr),
    .iRd        (rd),
    .iAddr      (addr),
    .iData      (data),
    .iLampTest  (lamp),
    .oRdData    (rd_data),
    .oLedPrd    (led_prd),
    .oLedPrm    (led_prm),
    .oBlinkPhase(phase)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  logic [15:0] m_reg[4];
  logic [15:0] m_rd, m_prd, m_prm;
  int          m_n;       // edges since reset release
  int          m_until;   // last edge index after which the FSM is still in test

  // The phase flips every BD edges and starts in the on phase.
  function automatic logic m_phase(input int k);
    return ((k / int'(BD)) % 2) == 0;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 16'h0;
    m_rd    = 16'h0;
    m_prd   = 16'h0;
    m_prm   = 16'h0;
    m_n     = 0;
    m_until = -1;
  endtask

  task automatic model_edge(input logic w, input logic r, input logic [1:0] a,
                            input logic [15:0] d, input logic l);
    logic [15:0] off_mask;
    off_mask = m_phase(m_n) ? 16'h0000 : 16'hFFFF;
    if (m_n <= m_until) begin
      m_prd = 16'hFFFF;
      m_prm = 16'hFFFF;
    end else begin
      m_prd = m_reg[0] & ~(m_reg[2] & off_mask);
      m_prm = m_reg[1] & ~(m_reg[3] & off_mask);
    end
    if (r) m_rd = m_reg[a];
    if (w) m_reg[a] = d;
    m_n++;
    if (l) m_until = m_n + int'(LT) - 1;
  endtask

  task automatic chk_model();
    chk("rd_data", rd_data, m_rd);
    chk("led_prd", led_prd, m_prd);
    chk("led_prm", led_prm, m_prm);
    chk("blink_phase", 16'(phase), 16'(m_phase(m_n)));
  endtask

  // One clock: drive the inputs, take the edge, update the model, and compare.
  task automatic cycle(input logic w, input logic r, input logic [1:0] a,
                       input logic [15:0] d, input logic l);
    wr = w; rd = r; addr = a; data = d; lamp = l;
    @(posedge clk);
    model_edge(w, r, a, d, l);
    #1;
    chk_model();
  endtask

  task automatic nop();
    cycle(1'b0, 1'b0, 2'd0, 16'h0, 1'b0);
  endtask

  task automatic do_reset();
    wr = 1'b0; rd = 1'b0; addr = 2'd0; data = 16'h0; lamp = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_prd_during", led_prd, 16'h0);
    chk("rst_prm_during", led_prm, 16'h0);
    chk("rst_rd_during", rd_data, 16'h0);
    chk("rst_phase_during", 16'(phase), 16'h1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("rst_prd_after", led_prd, 16'h0);
    chk("rst_prm_after", led_prm, 16'h0);
    chk("rst_rd_after", rd_data, 16'h0);
    chk("rst_phase_after", 16'(phase), 16'h1);
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [1:0]  addr;
    logic [15:0] data;
    logic [15:0] e_rd;
    logic [15:0] e_prd;
    logic [15:0] e_prm;
    logic        e_ph;
  } vec_t;

  vec_t tbl[8];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int ff_cnt;
    int run;
    logic last_ph;
    logic seen;

    // Expected values are for the edges right after reset release.
    tbl[0] = '{1'b1, 1'b0, 2'd0, 16'hAAAA, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 2'd1, 16'h5555, 16'h0000, 16'hAAAA, 16'h0000, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 2'd0, 16'h0000, 16'hAAAA, 16'hAAAA, 16'h5555, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 2'd1, 16'h0000, 16'h5555, 16'hAAAA, 16'h5555, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 2'd2, 16'hBEEF, 16'h0000, 16'hAAAA, 16'h5555, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 2'd2, 16'h0000, 16'hBEEF, 16'h0000, 16'h5555, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 2'd2, 16'h0000, 16'hBEEF, 16'h0000, 16'h5555, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 2'd0, 16'h0000, 16'hBEEF, 16'hAAAA, 16'h5555, 1'b1};

    // Reset, then the table: write/readback, read-before-write, a blink pass
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].data, 1'b0);
      chk($sformatf("tbl%0d_rd", i), rd_data, tbl[i].e_rd);
      chk($sformatf("tbl%0d_prd", i), led_prd, tbl[i].e_prd);
      chk($sformatf("tbl%0d_prm", i), led_prm, tbl[i].e_prm);
      chk($sformatf("tbl%0d_ph", i), 16'(phase), 16'(tbl[i].e_ph));
    end

    // Blink: ON=00FF and BLINK=010F. Bit 8 blinks with its ON bit clear, so it stays dark.
    do_reset();
    cycle(1'b1, 1'b0, 2'd0, 16'h00FF, 1'b0);
    cycle(1'b1, 1'b0, 2'd2, 16'h010F, 1'b0);
    nop();
    run = 0;
    seen = 1'b0;
    last_ph = m_phase(m_n);
    for (int i = 0; i < 24; i++) begin
      nop();
      chk("blink_img", led_prd, m_phase(m_n - 1) ? 16'h00FF : 16'h00F0);
      run++;
      if (phase !== last_ph) begin
        if (seen) chk("blink_period", 16'(run), 16'(BD));
        seen = 1'b1;
        run = 0;
        last_ph = phase;
      end
    end

    // Lamp test: a single pulse, with a write to PRD_ON during the test.
    do_reset();
    cycle(1'b1, 1'b0, 2'd1, 16'h0001, 1'b0);
    nop();
    ff_cnt = 0;
    cycle(1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      cycle(i == 1, 1'b0, 2'd0, 16'h1234, 1'b0);
      if (led_prd == 16'hFFFF && led_prm == 16'hFFFF) ff_cnt++;
      if (i == 2) chk("lamp_write_hidden", led_prd, 16'hFFFF);
    end
    chk("lamp_len", 16'(ff_cnt), 16'(LT));
    chk("lamp_post_prd", led_prd, 16'h1234);
    chk("lamp_post_prm", led_prm, 16'h0001);

    // Retrigger three edges into the test
    ff_cnt = 0;
    cycle(1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      cycle(1'b0, 1'b0, 2'd0, 16'h0, i == 2);
      if (led_prd == 16'hFFFF && led_prm == 16'hFFFF) ff_cnt++;
    end
    chk("retrig_len", 16'(ff_cnt), 16'(3 + LT));

    // Abort: an asynchronous reset in the middle of a test
    cycle(1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
    nop();
    nop();
    chk("abort_pre_prd", led_prd, 16'hFFFF);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_prd_now", led_prd, 16'h0);
    chk("abort_prm_now", led_prm, 16'h0);
    chk("abort_phase_now", 16'(phase), 16'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      nop();
      chk("abort_idle_prd", led_prd, 16'h0);
      chk("abort_idle_prm", led_prm, 16'h0);
    end

    // Randomised traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            16'($urandom), $urandom_range(0, 15) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
